norm_lzc_seq: RTL and testbench
===============================

# norm_lzc_seq

Multi-cycle leading-zero counter and shift-amount generator that sits directly upstream of the FPU normalization shifter. It accepts the unnormalized significand for int→fp conversion, subnormal-input fp→fp conversion or divsqrt results. It scans the significand MSB-first, CHUNK bits per cycle, and clamps the count to a caller-supplied limit. It then presents a stable {ShiftIn, ShiftAmt} pair to the shifter under a valid/ready handshake. This lets a one-shot wide LZC be replaced by a small iterative one on area-constrained configurations.

## Interface
- P: cvw_t configuration; uses P.NORMSHIFTSZ and P.LOGNORMSHIFTSZ.
- CHUNK, default 8: bits examined per scan cycle. P.NORMSHIFTSZ must be a multiple of CHUNK; elaboration fails otherwise.
- NCHUNK (derived): P.NORMSHIFTSZ/CHUNK.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous abort of any in-flight operation.
- InValid  in  1  LzcIn/MaxShift are valid.
- InReady  out  1  block can accept a new operand.
- LzcIn  in  P.NORMSHIFTSZ  significand to be normalized, MSB-aligned.
- MaxShift  in  P.LOGNORMSHIFTSZ  saturation limit for the shift amount (subnormal/underflow clamp).
- OutValid  out  1  ShiftIn/ShiftAmt/AllZero are valid.
- OutReady  in  1  downstream consumes the result.
- ShiftIn  out  P.NORMSHIFTSZ  registered copy of LzcIn, drives the normalization shifter.
- ShiftAmt  out  P.LOGNORMSHIFTSZ  min(leading-zero count, MaxShift).
- AllZero  out  1  captured LzcIn was all zeros.

## Operation
- States: IDLE, SCAN, DONE.
- InReady = (state==IDLE) | (state==DONE & OutReady). This is combinational from state and OutReady.
- Accept on InValid & InReady:
  - register LzcIn→ShiftIn and MaxShift;
  - set AllZero = (LzcIn==0);
  - clear the internal count (width P.LOGNORMSHIFTSZ+1) and the chunk index;
  - go to SCAN.
- SCAN: each cycle, examine chunk k (bits [N-1-k·CHUNK -: CHUNK]).
  - cand = count + (chunk≠0 ? lzc(chunk) : CHUNK).
  - If chunk≠0 or cand ≥ MaxShift: ShiftAmt ← min(cand, MaxShift), go to DONE.
  - Otherwise: count ← cand, k ← k+1, stay in SCAN.
- All-zero input always saturates by the last chunk, because cand reaches NORMSHIFTSZ > MaxShift. ShiftAmt is then MaxShift.
- DONE: OutValid=1. ShiftIn, ShiftAmt and AllZero are held stable while OutReady=0.
- DONE & OutReady: if InValid, accept the new operand and go to SCAN; else go to IDLE.
- Flush (synchronous) has the highest priority:
  - next state is IDLE and OutValid is 0 next cycle;
  - any InValid in that cycle is not accepted (InReady still reflects state, but the accept is suppressed);
  - ShiftIn, ShiftAmt and AllZero keep their old values.
- Reset (async, any state, including mid-SCAN): state IDLE; OutValid, ShiftAmt, ShiftIn, AllZero, count and index all 0. InReady is 1 while in reset.

## Timing
- Accept edge is T. Scan of chunk k occurs in cycle T+1+k.
- OutValid is asserted from edge T+2+k, where k is the terminating chunk. Minimum latency is 2 cycles; maximum is NCHUNK+1 cycles.
- Throughput: back-to-back operations are possible with the DONE→SCAN bypass. There are no IDLE bubbles when OutReady and InValid coincide.
- All outputs are registered; no combinational path from LzcIn to ShiftAmt.
- OutValid is never deasserted without OutReady or Flush.

## Test plan
Bench configuration: NORMSHIFTSZ=32, LOGNORMSHIFTSZ=5, CHUNK=8.

- **Leading one at MSB:** LzcIn=0x8000_0000, MaxShift=31, accept at T → OutValid at T+2, ShiftAmt=0, ShiftIn=0x8000_0000, AllZero=0.
- **Leading one in chunk 2:** LzcIn=0x0000_1000, MaxShift=31 → chunk 2 terminates, OutValid at T+4, ShiftAmt=19.
- **Early saturation:** LzcIn=0x0000_0001, MaxShift=10 → saturates at chunk 1 (cand=16), OutValid at T+3, ShiftAmt=10, AllZero=0.
- **All-zero input:** LzcIn=0, MaxShift=31 → OutValid at T+5, ShiftAmt=31, AllZero=1.
- **Backpressure then back-to-back:**
  - Hold OutReady=0 for 3 cycles in DONE → outputs stable, InReady=0.
  - Then OutReady=1 with InValid=1 and LzcIn=0x4000_0000 → new operand accepted that cycle, next OutValid 2 cycles later with ShiftAmt=1.
- **Flush and async reset mid-SCAN:**
  - Flush during SCAN of chunk 1 (LzcIn=0x0000_00FF) → OutValid never asserted, IDLE next cycle, InReady=1.
  - Repeat with reset pulled low mid-cycle → all outputs 0 immediately.

Source files
------------

// File: rtl/norm_lzc_seq_if.sv
// Operand/result handshake bundle between the FPU front end, the iterative LZC and the normalization shifter.
interface norm_lzc_seq_if #(
  parameter int unsigned NORMSHIFTSZ    = 32,
  parameter int unsigned LOGNORMSHIFTSZ = 5
);
  logic                      Flush;
  logic                      InValid;
  logic                      InReady;
  logic [NORMSHIFTSZ-1:0]    LzcIn;
  logic [LOGNORMSHIFTSZ-1:0] MaxShift;
  logic                      OutValid;
  logic                      OutReady;
  logic [NORMSHIFTSZ-1:0]    ShiftIn;
  logic [LOGNORMSHIFTSZ-1:0] ShiftAmt;
  logic                      AllZero;

  modport master (
    output Flush, InValid, LzcIn, MaxShift, OutReady,
    input  InReady, OutValid, ShiftIn, ShiftAmt, AllZero
  );

  modport slave (
    input  Flush, InValid, LzcIn, MaxShift, OutReady,
    output InReady, OutValid, ShiftIn, ShiftAmt, AllZero
  );
endinterface

// File: rtl/norm_lzc_seq.sv
// Iterative leading-zero counter: scans the captured significand CHUNK bits per cycle
// and presents a clamped {ShiftIn, ShiftAmt} pair to the normalization shifter.
module norm_lzc_seq #(
  parameter int unsigned NORMSHIFTSZ    = 32,
  parameter int unsigned LOGNORMSHIFTSZ = 5,
  parameter int unsigned CHUNK          = 8
) (
  input logic           clk,
  input logic           reset,
  norm_lzc_seq_if.slave io
);
  localparam int unsigned N      = NORMSHIFTSZ;
  localparam int unsigned L      = LOGNORMSHIFTSZ;
  localparam int unsigned CW     = L + 1;
  localparam int unsigned NCHUNK = N / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((N % CHUNK) != 0) begin : g_bad_chunk
    $error("NORMSHIFTSZ must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    shift_in;
  logic [L-1:0]    max_shift;
  logic [L-1:0]    shift_amt;
  logic            all_zero;
  logic            out_valid;
  logic [CW-1:0]   count;
  logic [IW-1:0]   idx;
  logic            hit;

  logic            in_ready;
  logic            accept;
  logic [N-1:0]    aligned;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]   lz;
  logic [CW-1:0]   cand;
  logic            sat;
  logic            stop;
  logic [L-1:0]    amt;

  assign in_ready = (state == IDLE) | ((state == DONE) & io.OutReady);
  assign accept   = io.InValid & in_ready;

  // Chunk under examination and the candidate count it would produce.
  always_comb begin
    aligned = shift_in << (32'(idx) * CHUNK);
    chunk   = aligned[N-1 -: CHUNK];
    lz      = CW'(CHUNK);
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if ((chunk & (CHUNK'(1) << i)) != '0) lz = CW'(CHUNK - 1 - i);
    end
    cand = count + lz;
    sat  = cand >= CW'(max_shift);
    stop = (chunk != '0) | sat | (idx == IW'(NCHUNK - 1));
    amt  = sat ? max_shift : cand[L-1:0];
  end

  // The scan records its result first; the following cycle it is published in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_in  <= '0;
      max_shift <= '0;
      shift_amt <= '0;
      all_zero  <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      idx       <= '0;
      hit       <= 1'b0;
    end else if (io.Flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        shift_in  <= io.LzcIn;
        max_shift <= io.MaxShift;
        all_zero  <= (io.LzcIn == '0);
        count     <= '0;
        idx       <= '0;
        hit       <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) state <= SCAN;
        end
        SCAN: begin
          if (hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (stop) begin
            shift_amt <= amt;
            hit       <= 1'b1;
          end else begin
            count <= cand;
            idx   <= idx + IW'(1);
          end
        end
        DONE: begin
          if (io.OutReady) begin
            out_valid <= 1'b0;
            state     <= accept ? SCAN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.InReady  = in_ready;
  assign io.OutValid = out_valid;
  assign io.ShiftIn  = shift_in;
  assign io.ShiftAmt = shift_amt;
  assign io.AllZero  = all_zero;
endmodule

// File: tb/tb_norm_lzc_seq.sv
// Bench for norm_lzc_seq: directed latency/value cases plus randomized traffic against a transaction-level model.
module tb_norm_lzc_seq;
  localparam int unsigned N   = 32;
  localparam int unsigned L   = 5;
  localparam int unsigned C   = 8;
  localparam int          NCH = N / C;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  norm_lzc_seq_if #(.NORMSHIFTSZ(N), .LOGNORMSHIFTSZ(L)) bus ();
  norm_lzc_seq #(.NORMSHIFTSZ(N), .LOGNORMSHIFTSZ(L), .CHUNK(C)) dut (
    .clk  (clk),
    .reset(rst_n),
    .io   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lzc(input logic [31:0] x);
    for (int i = 31; i >= 0; i--) if (x[i]) return 31 - i;
    return 32;
  endfunction

  // Cycles from accept edge to OutValid: the scan stops at the leading-one chunk
  // or at the first chunk whose running count reaches the limit, whichever is first.
  function automatic int lat_of(input logic [31:0] x, input int m);
    int lz, j, ks, k;
    lz = lzc(x);
    j  = lz / C;
    if (j > NCH - 1) j = NCH - 1;
    ks = (m == 0) ? 0 : (m + C - 1) / C - 1;
    k  = (lz < m) ? j : ((j < ks) ? j : ks);
    return k + 2;
  endfunction

  // Transaction-level model of the block's visible behaviour.
  bit          m_busy, m_valid, m_az, m_rdy;
  int          m_cnt, m_amt;
  logic [31:0] m_shiftin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_cnt = 0; m_amt = 0; m_az = 0; m_shiftin = '0;
    end else if (bus.Flush) begin
      m_busy = 0; m_valid = 0;
    end else begin
      m_rdy = (!m_busy && !m_valid) || (m_valid && bus.OutReady);
      if (m_valid && bus.OutReady) m_valid = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin m_busy = 0; m_valid = 1; end
      end
      if (m_rdy && bus.InValid) begin
        m_busy    = 1;
        m_cnt     = lat_of(bus.LzcIn, int'(bus.MaxShift));
        m_shiftin = bus.LzcIn;
        m_az      = (bus.LzcIn == 0);
        m_amt     = (lzc(bus.LzcIn) < int'(bus.MaxShift)) ? lzc(bus.LzcIn) : int'(bus.MaxShift);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", bus.OutValid, 0);
      chk("rst_in_ready", bus.InReady, 1);
      chk("rst_shift_amt", bus.ShiftAmt, 0);
      chk("rst_shift_in", bus.ShiftIn, 0);
      chk("rst_all_zero", bus.AllZero, 0);
    end else begin
      chk("in_ready", bus.InReady, (!m_busy && !m_valid) || (m_valid && bus.OutReady));
      chk("out_valid", bus.OutValid, m_valid);
      if (m_valid) begin
        chk("shift_amt", bus.ShiftAmt, m_amt);
        chk("shift_in", bus.ShiftIn, m_shiftin);
        chk("all_zero", bus.AllZero, m_az);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [4:0] m);
    int tmo;
    logic rdy;
    bus.InValid = 1'b1; bus.LzcIn = x; bus.MaxShift = m;
    tmo = 0;
    do begin
      @(negedge clk); rdy = bus.InReady;
      @(posedge clk); #1; tmo++;
    end while (!rdy && tmo < 50);
    bus.InValid = 1'b0;
    if (!rdy) chk("accept_timeout", 0, 1);
  endtask

  // Counts edges after the accept edge until OutValid is seen; returns at a negedge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus.OutValid && lat < 20);
  endtask

  task automatic directed(input string nm, input logic [31:0] x, input logic [4:0] m,
                          input int exp_lat, input int exp_amt, input bit exp_az);
    int lat;
    bus.OutReady = 1'b1;
    send(x, m);
    wait_valid(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_amt"}, bus.ShiftAmt, exp_amt);
    chk({nm, "_shift_in"}, bus.ShiftIn, x);
    chk({nm, "_all_zero"}, bus.AllZero, exp_az);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int sh;
    bus.Flush = 1'b0; bus.InValid = 1'b0; bus.LzcIn = '0; bus.MaxShift = '0; bus.OutReady = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    directed("msb",    32'h8000_0000, 5'd31, 2, 0,  1'b0);
    directed("chunk2", 32'h0000_1000, 5'd31, 4, 19, 1'b0);
    directed("sat",    32'h0000_0001, 5'd10, 3, 10, 1'b0);
    directed("zero",   32'h0000_0000, 5'd31, 5, 31, 1'b1);

    // Backpressure in DONE, then a back-to-back accept on the releasing edge.
    bus.OutReady = 1'b0;
    send(32'h00F0_0000, 5'd20);
    wait_valid(lat);
    chk("bp_lat", lat, 3);
    chk("bp_amt", bus.ShiftAmt, 8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("bp_hold_valid", bus.OutValid, 1);
      chk("bp_hold_in_ready", bus.InReady, 0);
      chk("bp_hold_amt", bus.ShiftAmt, 8);
      chk("bp_hold_shift_in", bus.ShiftIn, 32'h00F0_0000);
    end
    @(posedge clk); #1;
    bus.OutReady = 1'b1; bus.InValid = 1'b1; bus.LzcIn = 32'h4000_0000; bus.MaxShift = 5'd31;
    @(negedge clk);
    chk("b2b_in_ready", bus.InReady, 1);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    wait_valid(lat);
    chk("b2b_lat", lat, 2);
    chk("b2b_amt", bus.ShiftAmt, 1);
    @(posedge clk); #1;

    // Flush while chunk 1 is being scanned.
    send(32'h0000_00FF, 5'd31);
    @(posedge clk); #1;
    bus.Flush = 1'b1;
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    chk("flush_out_valid", bus.OutValid, 0);
    chk("flush_in_ready", bus.InReady, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_no_valid", bus.OutValid, 0);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-scan.
    send(32'h0000_00FF, 5'd31);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("areset_out_valid", bus.OutValid, 0);
    chk("areset_amt", bus.ShiftAmt, 0);
    chk("areset_shift_in", bus.ShiftIn, 0);
    chk("areset_all_zero", bus.AllZero, 0);
    chk("areset_in_ready", bus.InReady, 1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with backpressure and occasional flushes.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.InValid  = ($urandom_range(0, 1) == 1);
      sh           = int'($urandom_range(0, 32));
      bus.LzcIn    = 32'($urandom) >> sh;
      bus.MaxShift = 5'($urandom_range(0, 31));
      bus.OutReady = ($urandom_range(0, 9) < 7);
      bus.Flush    = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    bus.InValid = 1'b0; bus.Flush = 1'b0; bus.OutReady = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
